// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared definitions for the PS/2 host transmitter and its
//             neighbours. Holds the transmitter state encoding, the common
//             keyboard command bytes and the frame parity helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones in
    // {data, parity} odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_sync
//  Purpose  : Two-flop synchronizer for the raw PS/2 clock and data pins plus
//             a single-cycle strobe on each falling edge of the synchronized
//             clock. Also used by the scancode receiver on the same pins.
//  Ports    : clk, rst        - system clock, synchronous active-high reset
//             ps2_clk_i       - raw PS/2 clock pin (asynchronous)
//             ps2_data_i      - raw PS/2 data pin (asynchronous)
//             clk_sync_o      - synchronized PS/2 clock level
//             data_sync_o     - synchronized PS/2 data level
//             clk_fall_o      - one-cycle strobe: synced clock went 1 -> 0
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic [1:0] clk_pipe_q;
    logic [1:0] data_pipe_q;
    logic       clk_prev_q;

    // Reset to the idle (released, high) bus level so leaving reset never
    // produces a spurious falling-edge strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_pipe_q  <= 2'b11;
            data_pipe_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_pipe_q  <= {clk_pipe_q[0], ps2_clk_i};
            data_pipe_q <= {data_pipe_q[0], ps2_data_i};
            clk_prev_q  <= clk_pipe_q[1];
        end
    end

    assign clk_sync_o  = clk_pipe_q[1];
    assign data_sync_o = data_pipe_q[1];
    assign clk_fall_o  = clk_prev_q & ~clk_pipe_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 transmitter. Sends one command byte to the
//             keyboard by inhibiting the bus, issuing request-to-send and
//             shifting the frame out on device-generated clock edges.
//  Ports    : clk, rst               - system clock, sync active-high reset
//             ps2_clk_in/ps2_data_in - raw PS/2 pins
//             ps2_clk_oe/ps2_data_oe - 1 = pull line low, 0 = release
//             tx_data, tx_start      - byte and one-cycle send request
//             tx_busy                - frame in flight (state != IDLE)
//             tx_done, tx_error      - one-cycle completion pulses
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       frame_q, frame_d;      // {parity, data}
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             clk_sync;
    logic             data_sync;
    logic             clk_fall;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk_in),
        .ps2_data_i  (ps2_data_in),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // REQ reloads the counter with 1, so during SEND/ACK/WAIT_IDLE it holds
    // the number of cycles elapsed since REQ. Firing at TIMEOUT_CYCLES-1
    // makes tx_error appear exactly TIMEOUT_CYCLES cycles after REQ.
    assign timeout_hit = (cnt_q == TMO_LAST);

    // State and datapath register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            bit_idx_q <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    frame_d = {odd_parity(tx_data), tx_data};
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            REQ: begin
                cnt_d     = CNT_W'(1);
                bit_idx_d = '0;
                data_oe_d = 1'b1;            // keep start bit asserted
                state_d   = SEND;
            end
            SEND, ACK, WAIT_IDLE: begin
                cnt_d = cnt_inc;
                // Timeout wins over any simultaneous clock edge.
                if (timeout_hit) begin
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = IDLE;
                end else if (state_q == SEND) begin
                    if (clk_fall) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd9) begin
                            data_oe_d = 1'b0;    // stop bit: release
                            state_d   = ACK;
                        end else begin
                            // indices 0-7 are data, 8 is parity
                            data_oe_d = ~frame_q[bit_idx_q];
                        end
                    end
                end else if (state_q == ACK) begin
                    if (clk_fall) begin
                        if (!data_sync) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    if (clk_sync && data_sync) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            INHIBIT: ps2_clk_oe = 1'b1;
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            SEND:    ps2_data_oe = data_oe_q;
            default: ;
        endcase
        tx_busy  = (state_q != IDLE);
        tx_done  = done_q;
        tx_error = error_q;
    end

endmodule
`default_nettype wire
